// File: rtl/wrr_forward_arbiter_pkg.sv
// rtl/wrr_forward_arbiter_pkg.sv - shared types and helpers for the weighted round-robin arbiter
//
// Purpose : arbiter FSM state type and index-width helper used by the
//           arbiter top and by the circular ready search.
// Contents: arb_state_t  - IDLE (no owner) / BURST (owner holds the grant)
//           idx_w(n)     - bits needed to index n sources (at least 1)
package wrr_forward_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_ready.sv
// rtl/rr_next_ready.sv - combinational circular first-set search starting at a given index
//
// Purpose : returns the first set bit of req at or after start, wrapping
//           around, so a search started at owner+1 ends on owner itself.
// Ports   : req   in  N   request vector
//           start in  IW  first index examined (must be < N)
//           found out 1   any bit of req set
//           idx   out IW  index of the first set bit found (0 when none)
module rr_next_ready
  import wrr_forward_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(start) + k) % N);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/wrr_forward_arbiter.sv
// rtl/wrr_forward_arbiter.sv - work-conserving weighted round-robin arbiter onto one registered rdy/ack sink
//
// Purpose : shares one rdy/ack consumer between N rdy/ack producers. The
//           owner keeps the grant for up to max(weight,1) consecutive
//           transfers; idle sources are skipped without a bubble.
// Ports   : i_clk      in  1     clock
//           i_rstn     in  1     asynchronous reset, active low
//           src_rdys   in  N     per-source ready
//           src_acks   out N     per-source ack, at most one bit set
//           src_datas  in  N*DW  per-source data
//           weights    in  N*WW  burst quota per source, sampled at grant start
//           dst_rdy    out 1     output valid (registered)
//           dst_ack    in  1     output accepted
//           dst_data   out DW    registered data
//           dst_src    out IW    source index of dst_data
module wrr_forward_arbiter
  import wrr_forward_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int WW = 4,
  localparam int IW = idx_w(N)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [N-1:0]    src_rdys,
  output logic [N-1:0]    src_acks,
  input  logic [N*DW-1:0] src_datas,
  input  logic [N*WW-1:0] weights,
  output logic            dst_rdy,
  input  logic            dst_ack,
  output logic [DW-1:0]   dst_data,
  output logic [IW-1:0]   dst_src
);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [WW-1:0] credit;

  logic          can_load;
  logic [IW-1:0] search_start;
  logic          next_found;
  logic [IW-1:0] next_idx;
  logic          keep_owner;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          take;
  logic [WW-1:0] w_next;
  logic [WW-1:0] credit_load;
  logic [DW-1:0] grant_data;

  assign can_load = !dst_rdy || dst_ack;

  // Search starts just past the owner; in IDLE the kept owner acts as the
  // fairness pointer, and during rotation the owner is examined last.
  assign search_start = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

  rr_next_ready #(.N(N)) u_next (
    .req   (src_rdys),
    .start (search_start),
    .found (next_found),
    .idx   (next_idx)
  );

  // Owner continues only while it has quota left and is presenting data;
  // otherwise the grant goes to the next ready source in the same cycle.
  assign keep_owner  = (state == ARB_BURST) && src_rdys[owner] && (credit != '0);
  assign grant_valid = keep_owner || next_found;
  assign grant_idx   = keep_owner ? owner : next_idx;
  assign take        = grant_valid && can_load;

  // Reset only masks the ack output; the registers are already held in reset.
  assign src_acks = (take && i_rstn) ? (N'(1) << grant_idx) : '0;

  always_comb begin
    w_next     = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (next_idx == IW'(i)) w_next = weights[i*WW +: WW];
      if (grant_idx == IW'(i)) grant_data = src_datas[i*DW +: DW];
    end
  end

  // Credit counts transfers remaining after the granting one; weight 0 acts as 1.
  assign credit_load = (w_next == '0) ? '0 : w_next - WW'(1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      credit <= '0;
    end else if (take) begin
      state <= ARB_BURST;
      if (keep_owner) begin
        credit <= credit - WW'(1);
      end else begin
        owner  <= next_idx;
        credit <= credit_load;
      end
    end else if (!grant_valid) begin
      // Nothing ready anywhere: drop the grant but keep owner as the pointer.
      state <= ARB_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dst_rdy  <= 1'b0;
      dst_data <= '0;
      dst_src  <= '0;
    end else if (can_load) begin
      dst_rdy <= take;
      if (take) begin
        dst_data <= grant_data;
        dst_src  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_wrr_forward_arbiter.sv
// tb/tb_wrr_forward_arbiter.sv - self-checking bench for wrr_forward_arbiter
module tb_wrr_forward_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    src_rdys;
  logic [N-1:0]    src_acks;
  logic [N*DW-1:0] src_datas;
  logic [N*WW-1:0] weights;
  logic            dst_rdy;
  logic            dst_ack;
  logic [DW-1:0]   dst_data;
  logic [IW-1:0]   dst_src;

  always #5 clk = ~clk;

  wrr_forward_arbiter #(.N(N), .DW(DW), .WW(WW)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .src_rdys  (src_rdys),
    .src_acks  (src_acks),
    .src_datas (src_datas),
    .weights   (weights),
    .dst_rdy   (dst_rdy),
    .dst_ack   (dst_ack),
    .dst_data  (dst_data),
    .dst_src   (dst_src)
  );

  int checks   = 0;
  int failures = 0;

  // source environment
  int src_seq[N];
  bit src_en[N];
  int rdy_pct;
  int seq_exp[N];

  // reference model: grant pointer plus remaining quota, registered output
  int            m_owner;
  int            m_quota;
  bit            m_valid;
  int            m_src;
  logic [DW-1:0] m_data;

  int log_q[$];

  int seq_a[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
  int seq_b[11] = '{1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
  int seq_c[10] = '{2, 2, 2, 2, 2, 2, 0, 2, 2, 0};
  int seq_e[6]  = '{1, 1, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int i, input int s);
    return DW'(i * 4096 + s);
  endfunction

  function automatic int ack_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r < 0) ? i : 99;
    return r;
  endfunction

  function automatic int weight_of(input int i);
    int w = int'(weights[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic sources_update(input logic [N-1:0] acked);
    for (int i = 0; i < N; i++) begin
      if (acked[i] || !src_rdys[i]) begin
        if (acked[i]) src_seq[i]++;
        src_rdys[i] = src_en[i] && ($urandom_range(99) < rdy_pct);
        src_datas[i*DW +: DW] = data_of(i, src_seq[i]);
      end
    end
  endtask

  // One clock: check DUT against the model mid-cycle, then advance both.
  task automatic cycle();
    logic [N-1:0] exp_acks;
    logic [N-1:0] acked;
    bit can_load, any, cont;
    int g;
    @(negedge clk);
    can_load = !m_valid || dst_ack;
    any      = |src_rdys;
    cont     = (m_quota > 0) && src_rdys[m_owner];
    g        = -1;
    if (can_load && any) begin
      if (cont) g = m_owner;
      else for (int k = 1; k <= N; k++) begin
        int j = (m_owner + k) % N;
        if (g < 0 && src_rdys[j]) g = j;
      end
    end
    exp_acks = (g >= 0) ? (N'(1) << g) : '0;
    chk("src_acks", src_acks, exp_acks);
    chk("dst_rdy", dst_rdy, m_valid);
    if (m_valid) begin
      chk("dst_src", dst_src, m_src);
      chk("dst_data", dst_data, m_data);
    end
    if (dst_rdy && dst_ack) begin
      chk("scoreboard", dst_data, data_of(int'(dst_src), seq_exp[int'(dst_src)]));
      seq_exp[int'(dst_src)]++;
    end
    log_q.push_back(ack_idx(src_acks));
    acked = src_acks;
    if (!any) m_quota = 0;
    if (can_load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        if (cont) m_quota--;
        else begin
          m_owner = g;
          m_quota = weight_of(g) - 1;
        end
        m_src  = g;
        m_data = src_datas[g*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
    sources_update(acked);
  endtask

  task automatic apply_reset(input int n);
    rstn = 1'b0;
    #1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_acks", src_acks, 0);
      chk("rst_dst_rdy", dst_rdy, 0);
      chk("rst_dst_data", dst_data, 0);
      chk("rst_dst_src", dst_src, 0);
    end
    @(posedge clk);
    #1;
    m_owner = 0;
    m_quota = 0;
    m_valid = 0;
    m_src   = 0;
    m_data  = '0;
    for (int i = 0; i < N; i++) begin
      seq_exp[i] = src_seq[i];
      src_rdys[i] = src_en[i] && ($urandom_range(99) < rdy_pct);
      src_datas[i*DW +: DW] = data_of(i, src_seq[i]);
    end
    log_q.delete();
    rstn = 1'b1;
  endtask

  task automatic set_all(input bit en, input int pct);
    for (int i = 0; i < N; i++) src_en[i] = en;
    rdy_pct = pct;
  endtask

  initial begin
    dst_ack   = 1'b1;
    weights   = {4'd1, 4'd1, 4'd1, 4'd1};
    src_rdys  = '1;
    src_datas = '0;
    for (int i = 0; i < N; i++) begin
      src_seq[i] = 0;
      seq_exp[i] = 0;
      src_datas[i*DW +: DW] = data_of(i, 0);
    end
    set_all(1, 100);

    // reset with every source ready, then equal weights
    apply_reset(3);
    repeat (8) cycle();
    foreach (seq_a[k]) chk("seq_equal_w", log_q[k], seq_a[k]);

    // unequal weights src0..3 = 3,1,2,1
    weights = {4'd1, 4'd2, 4'd1, 4'd3};
    apply_reset(1);
    repeat (11) cycle();
    foreach (seq_b[k]) chk("seq_weighted", log_q[k], seq_b[k]);

    // backpressure: nothing acked, output held
    dst_ack = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_no_ack", log_q[$], -1);
    end
    dst_ack = 1'b1;
    repeat (12) cycle();

    // single ready source reloads its quota, then src0 joins
    weights = {4'd1, 4'd2, 4'd1, 4'd1};
    set_all(0, 100);
    src_en[2] = 1;
    apply_reset(1);
    repeat (6) cycle();
    src_en[0] = 1;
    src_rdys[0] = 1'b1;
    repeat (4) cycle();
    foreach (seq_c[k]) chk("seq_single", log_q[k], seq_c[k]);

    // reset in the middle of a weight-3 burst
    weights = {4'd1, 4'd1, 4'd3, 4'd1};
    set_all(1, 100);
    apply_reset(1);
    cycle();
    chk("burst_first", log_q[0], 1);
    rstn = 1'b0;
    #1;
    chk("async_dst_rdy", dst_rdy, 0);
    chk("async_dst_src", dst_src, 0);
    chk("async_dst_data", dst_data, 0);
    apply_reset(1);
    repeat (6) cycle();
    foreach (seq_e[k]) chk("seq_after_rst", log_q[k], seq_e[k]);

    // randomized traffic, weights and backpressure
    set_all(1, 70);
    repeat (3000) begin
      dst_ack = ($urandom_range(3) != 0);
      if ($urandom_range(99) < 3) weights = N*WW'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
